// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_pkg
//  Purpose  : Shared definitions for the UART transmit and receive paths:
//             data width, frame state encoding and the bit-period helper.
//  Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

  localparam int DATA_W = 8;

  // Encoding is shared with the receiver, so the values are pinned.
  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START_BIT  = 3'd1,
    DATA_BITS  = 3'd2,
    PARITY_BIT = 3'd3,
    STOP_BIT   = 3'd4
  } uart_state_e;

  // Clock cycles per bit period (integer division, rounds down).
  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_bit_timer.sv
`default_nettype none
// ============================================================================
//  Module   : uart_bit_timer
//  Purpose  : Free-running bit-period counter. Counts 0..CLKS_PER_BIT-1 and
//             pulses o_bit_done for one cycle on the last count, then wraps.
//  Ports    : clk        - system clock, rising edge
//             rst_n      - asynchronous active-low reset
//             i_restart  - hold/force the count to 0
//             o_bit_done - one-cycle pulse at the end of each bit period
//  Revision : 1.0 - initial release
// ============================================================================
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_restart,
  output logic o_bit_done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] r_clk_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clk_cnt <= '0;
    end else if (i_restart || (r_clk_cnt == CNT_LAST)) begin
      r_clk_cnt <= '0;
    end else begin
      r_clk_cnt <= r_clk_cnt + 1'b1;
    end
  end

  // Decoded straight from the counter flop; CNT_LAST is never 0, so the
  // pulse cannot fire while the counter is held in restart.
  assign o_bit_done = (r_clk_cnt == CNT_LAST);

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx
//  Purpose  : UART transmitter. Bytes enter through a valid/ready handshake
//             into a one-entry holding register and are sent LSB-first as
//             start bit, 8 data bits, optional parity bit and STOP_BITS stop
//             bits. Queued bytes follow the previous stop bit with no idle gap.
//  Config   : UART_TX_PARITY_EN - when defined, adds a parity bit after data
//             bit 7 (parameter PARITY_ODD: 0 = even, 1 = odd).
//  Ports    : clk   - system clock, rising edge
//             rst_n - asynchronous active-low reset
//             data  - byte to transmit
//             valid - data valid this cycle
//             ready - holding register empty (registered)
//             tx    - serial line, idle high (registered)
//             busy  - frame on the line or byte held (registered)
//  Revision : 1.0 - initial release
// ============================================================================
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD_RATE = 9600,
  parameter int STOP_BITS = 1
`ifdef UART_TX_PARITY_EN
  ,
  parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data,
  input  logic              valid,
  output logic              ready,
  output logic              tx,
  output logic              busy
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int IDX_W        = $clog2(DATA_W);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
    $error("uart_tx: CLK_FREQ / BAUD_RATE must be at least 2");
  end
  if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop_bits
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end

  uart_state_e       r_state;
  logic [DATA_W-1:0] r_hold;
  logic              r_hold_full;
  logic              r_ready;
  logic [DATA_W-1:0] r_shift;
  logic [IDX_W-1:0]  r_bit_idx;
  logic              r_stop_cnt;
  logic              r_tx;
  logic              r_busy;

  logic w_bit_done;
  logic w_accept;
  logic w_last_stop;
  logic w_go_idle;

  // Counter is parked at 0 while idle so the start bit gets a full period.
  uart_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_bit_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_restart  (r_state == IDLE),
    .o_bit_done (w_bit_done)
  );

  assign w_accept    = valid && r_ready;
  assign w_last_stop = (STOP_BITS == 1) || (r_stop_cnt == 1'b1);
  // Frame ends with nothing queued: the only way back to IDLE.
  assign w_go_idle   = (r_state == STOP_BIT) && w_bit_done && w_last_stop
                       && !r_hold_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_ready     <= 1'b1;
      r_shift     <= '0;
      r_bit_idx   <= '0;
      r_stop_cnt  <= 1'b0;
      r_tx        <= 1'b1;
      r_busy      <= 1'b0;
    end else begin
      // busy is computed from next-state terms so the output is a single
      // flop and cannot glitch when state and hold_full change together.
      r_busy <= w_accept || r_hold_full || ((r_state != IDLE) && !w_go_idle);

      // Accept and load are mutually exclusive: ready is low while full.
      if (w_accept) begin
        r_hold      <= data;
        r_hold_full <= 1'b1;
        r_ready     <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          r_tx <= 1'b1;
          if (r_hold_full) begin
            r_shift     <= r_hold;
            r_hold_full <= 1'b0;
            r_ready     <= 1'b1;
            r_bit_idx   <= '0;
            r_tx        <= 1'b0;
            r_state     <= START_BIT;
          end
        end

        START_BIT: begin
          if (w_bit_done) begin
            r_bit_idx <= '0;
            r_tx      <= r_shift[0];
            r_state   <= DATA_BITS;
          end
        end

        DATA_BITS: begin
          if (w_bit_done) begin
            if (r_bit_idx == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
              r_tx    <= (^r_shift) ^ PARITY_ODD;
              r_state <= PARITY_BIT;
`else
              r_tx       <= 1'b1;
              r_stop_cnt <= 1'b0;
              r_state    <= STOP_BIT;
`endif
            end else begin
              r_bit_idx <= r_bit_idx + 1'b1;
              r_tx      <= r_shift[r_bit_idx + 1'b1];
            end
          end
        end

`ifdef UART_TX_PARITY_EN
        PARITY_BIT: begin
          if (w_bit_done) begin
            r_tx       <= 1'b1;
            r_stop_cnt <= 1'b0;
            r_state    <= STOP_BIT;
          end
        end
`endif

        STOP_BIT: begin
          if (w_bit_done) begin
            if (w_last_stop) begin
              r_stop_cnt <= 1'b0;
              if (r_hold_full) begin
                // Chain straight into the next start bit, no idle cycle.
                r_shift     <= r_hold;
                r_hold_full <= 1'b0;
                r_ready     <= 1'b1;
                r_bit_idx   <= '0;
                r_tx        <= 1'b0;
                r_state     <= START_BIT;
              end else begin
                r_tx    <= 1'b1;
                r_state <= IDLE;
              end
            end else begin
              r_stop_cnt <= 1'b1;
            end
          end
        end

        default: begin
          r_tx    <= 1'b1;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign ready = r_ready;
  assign tx    = r_tx;
  assign busy  = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx
//  Purpose  : Self-checking bench for uart_tx. Stimulus pushes every accepted
//             byte into a queue; an independent line monitor decodes frames
//             from tx and compares them against a frame model built from the
//             byte value (start 0, data LSB-first, parity, stop 1s).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx;

  localparam int CPB = 10;
`ifdef UART_TX_PARITY_EN
  localparam int STOP = 2;
  localparam int PAR  = 1;
`else
  localparam int STOP = 1;
  localparam int PAR  = 0;
`endif
  localparam bit ODD        = 1'b0;
  localparam int FRAME_BITS = 9 + PAR + STOP;
  localparam int FRAME_CYC  = FRAME_BITS * CPB;
  localparam int TIMEOUT    = 1000;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] data  = 8'h00;
  logic       valid = 1'b0;
  logic       ready;
  logic       tx;
  logic       busy;

  longint cyc = 0;
  int checks = 0;
  int failures = 0;
  int rx_count = 0;

  logic [7:0] exp_q[$];
  longint     start_q[$];

  uart_tx #(
    .CLK_FREQ  (1_000_000),
    .BAUD_RATE (100_000),
    .STOP_BITS (STOP)
`ifdef UART_TX_PARITY_EN
    ,
    .PARITY_ODD(ODD)
`endif
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .data  (data),
    .valid (valid),
    .ready (ready),
    .tx    (tx),
    .busy  (busy)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Line level expected for frame bit k of byte b.
  function automatic logic exp_level(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if ((PAR == 1) && (k == 9)) return (^b) ^ ODD;
    return 1'b1;
  endfunction

  // Call at a negedge. Holds valid until ready; returns at the negedge after
  // the accepting edge, acc = index of that edge.
  task automatic send(input logic [7:0] b, output longint acc);
    int n = 0;
    data  = b;
    valid = 1'b1;
    while (ready !== 1'b1 && n < TIMEOUT) begin
      @(negedge clk);
      n++;
    end
    check("accept_timeout", ready, 1);
    if (ready !== 1'b1) begin
      valid = 1'b0;
      acc   = -1;
      return;
    end
    acc = cyc + 1;
    exp_q.push_back(b);
    @(negedge clk);
    valid = 1'b0;
    data  = 8'($urandom);
  endtask

  task automatic wait_idle(output longint c);
    int n = 0;
    @(negedge clk);
    while ((busy !== 1'b0 || exp_q.size() != 0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", (n >= 2000) ? 1 : 0, 0);
    c = cyc;
  endtask

  // Line monitor / scoreboard checker.
  initial begin : monitor
    longint     s;
    logic [7:0] eb;
    logic [7:0] dec;
    logic       have;
    logic       ab;
    logic       stop_ok;
    int         bad;
    logic       smp [0:15];
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && tx === 1'b0) begin
        s    = cyc;
        have = (exp_q.size() != 0);
        eb   = have ? exp_q[0] : 8'h00;
        ab   = 1'b0;
        bad  = 0;
        for (int k = 0; k < FRAME_BITS && !ab; k++) begin
          for (int c = 0; c < CPB && !ab; c++) begin
            if (k != 0 || c != 0) begin
              @(negedge clk);
              if (rst_n !== 1'b1) ab = 1'b1;
            end
            if (!ab) begin
              if (tx !== exp_level(eb, k)) bad++;
              if (c == CPB / 2) smp[k] = tx;
            end
          end
        end
        if (!ab) begin
          if (!have) begin
            check("spurious_frame", 1, 0);
          end else begin
            void'(exp_q.pop_front());
            for (int i = 0; i < 8; i++) dec[i] = smp[i+1];
            stop_ok = 1'b1;
            for (int k = 9 + PAR; k < FRAME_BITS; k++) stop_ok = stop_ok & smp[k];
            check("start_bit", smp[0], 0);
            check("data_byte", dec, eb);
`ifdef UART_TX_PARITY_EN
            check("parity_bit", smp[9], exp_level(eb, 9));
`endif
            check("stop_bits", stop_ok, 1);
            check("bit_timing_errors", bad, 0);
            rx_count++;
            start_q.push_back(s);
          end
        end
      end
    end
  end

  initial begin : stimulus
    longint e, a1, a2, c;
    int     bad, r0;

    // Reset and idle
    repeat (3) @(negedge clk);
    check("reset_tx", tx, 1);
    check("reset_ready", ready, 1);
    check("reset_busy", busy, 0);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || ready !== 1'b1 || busy !== 1'b0) bad++;
    end
    check("idle_after_reset", bad, 0);

    // Single byte 0xA5: latency and busy drop
    start_q.delete();
    send(8'hA5, e);
    repeat (100) @(negedge clk);
    check("a5_busy_last_cycle", busy, 1);
    @(negedge clk);
    check("a5_busy_drop", busy, 0);
    check("a5_frames", start_q.size(), 1);
    if (start_q.size() > 0) check("a5_latency", start_q[0], e + 1);

    // Back-to-back 0x00, 0xFF
    start_q.delete();
    repeat (5) @(negedge clk);
    send(8'h00, a1);
    check("b2b_ready_held", ready, 0);
    @(negedge clk);
    check("b2b_ready_after_load", ready, 1);
    send(8'hFF, a2);
    wait_idle(c);
    check("b2b_frames", start_q.size(), 2);
    if (start_q.size() == 2) begin
      check("b2b_gap", start_q[1] - start_q[0], FRAME_CYC);
      check("b2b_total", c - start_q[0], 2 * FRAME_CYC);
    end

    // Backpressure: 0x3C offered while hold register is full
    r0 = rx_count;
    send(8'h11, a1);
    send(8'h22, a2);
    check("bp_ready_low", ready, 0);
    send(8'h3C, e);
    wait_idle(c);
    repeat (30) @(negedge clk);
    check("bp_frames", rx_count - r0, 3);

    // Reset during data bit 4 of 0x55
    send(8'h55, e);
    repeat (55) @(negedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("midreset_tx", tx, 1);
    check("midreset_busy", busy, 0);
    check("midreset_ready", ready, 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) bad++;
    end
    check("midreset_quiet", bad, 0);
    r0 = rx_count;
    send(8'h81, e);
    wait_idle(c);
    check("after_reset_frames", rx_count - r0, 1);

    // Frame length (parity + 2 stop bits when enabled)
    start_q.delete();
    send(8'h07, e);
    wait_idle(c);
    check("len_frames", start_q.size(), 1);
    if (start_q.size() > 0) check("frame_len", c - start_q[0], FRAME_CYC);

    // Randomized bytes with random gaps (0 = back-to-back)
    r0 = rx_count;
    for (int i = 0; i < 24; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(8'($urandom), e);
    end
    wait_idle(c);
    check("random_frames", rx_count - r0, 24);

    repeat (20) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- UART transmitter; the transmit-side counterpart of the 8N1 receive path; drives the serial TX line.
- Accepts bytes over a valid/ready handshake into a 1-entry holding register.
- Serialises each byte LSB-first: start bit, 8 data bits, optional parity bit, STOP_BITS stop bits.
- Back-to-back bytes go out with no idle gap between frames.

Parameters:
- CLK_FREQ, 100_000_000: clock frequency in Hz.
- BAUD_RATE, 9600: line rate in bit/s.
- STOP_BITS, 1: number of stop bits; legal values 1 or 2.
- Derived localparam CLKS_PER_BIT = CLK_FREQ / BAUD_RATE (integer division; 10416 at defaults). Must be >= 2, checked by elaboration assertion.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- data  input  8  byte to transmit.
- valid  input  1  data is valid this cycle.
- ready  output  1  holding register empty; byte accepted on a rising edge where valid && ready.
- tx  output  1  serial line, idle high; registered output.
- busy  output  1  high while a frame is on the line or a byte is held.

Behaviour:
- Reset: one clock, clk; reset is asynchronous and active-low on rst_n. While rst_n = 0:
  - tx = 1, ready = 1, busy = 0, hold_full = 0, state = IDLE;
  - bit counter, bit index and shift register = 0.
- Reset asserted mid-frame aborts the frame immediately; tx returns high asynchronously, no truncated frame resumes.
- ready is !hold_full, driven from a flop, with no combinational path from valid.
- Accept on an edge with valid && ready: hold register <= data, hold_full <= 1. valid while ready = 0 is ignored and the data is dropped; the sender must hold it.
- State IDLE (tx = 1): if hold_full, load shift register from hold, clear hold_full, clk_cnt <= 0, go to START_BIT.
  - Latency: byte accepted at edge E, tx falls at edge E+1.
- START_BIT: tx = 0 for CLKS_PER_BIT cycles, then DATA_BITS with bit_index = 0.
- DATA_BITS: tx = shift[bit_index] for CLKS_PER_BIT cycles per bit. After bit 7 go to PARITY_BIT if enabled, else STOP_BIT.
- STOP_BIT: tx = 1 for STOP_BITS*CLKS_PER_BIT cycles.
  - On the final cycle, if hold_full: load and go straight to START_BIT, so tx falls on the next edge with no extra idle cycle.
  - On the final cycle, if hold empty: go to IDLE.
- Bit timing: clk_cnt counts 0..CLKS_PER_BIT-1, then wraps to 0 and advances. Width is $clog2(CLKS_PER_BIT) bits. Stop-bit duration uses a separate 1-bit stop counter.
- Frame length is exactly (10 + parity + STOP_BITS - 1) * CLKS_PER_BIT cycles.
- The hold register may be refilled at any time during a frame once ready = 1. A load and an accept never coincide, because ready = 0 whenever hold_full = 1.
- busy = (state != IDLE) || hold_full, registered-equivalent, glitch-free.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined:
  - adds parameter PARITY_ODD, default 0;
  - adds state PARITY_BIT, one bit-time after data bit 7;
  - tx = ^data XOR PARITY_ODD, i.e. even parity by default.
- Undefined: no PARITY_BIT state or parity logic; the frame is 8N1 (or 8N2).

Decomposition:
- Package uart_pkg holds:
  - state encoding constants IDLE = 0, START_BIT = 1, DATA_BITS = 2, PARITY_BIT = 3, STOP_BIT = 4 (3-bit), shared with the receiver;
  - function clks_per_bit(clk_freq, baud);
  - DATA_W = 8.
- Sub-module uart_bit_timer: the bit counter. It takes clk, rst_n, restart and emits a 1-cycle bit_done pulse every CLKS_PER_BIT cycles. The receiver can reuse it.

Test Plan:
- Bench params CLK_FREQ = 1_000_000, BAUD_RATE = 100_000 (CLKS_PER_BIT = 10) for all scenarios.
- Reset then idle: after rst_n release, expect tx = 1, ready = 1, busy = 0 for 100 cycles.
- Single byte 0xA5, one-cycle valid at edge E:
  - tx low at E+1 for 10 cycles;
  - then 1,0,1,0,0,1,0,1 at 10 cycles each;
  - then high for 10 cycles; busy drops at E+101.
- Back-to-back 0x00 then 0xFF, second offered while first is shifting:
  - ready = 0 until the first load;
  - second start bit follows the first stop bit with zero idle cycles;
  - total 200 cycles.
- Backpressure: hold valid with 0x3C while hold_full = 1. Expect no accept until ready = 1; exactly one 0x3C frame is sent, with no duplicate.
- Reset mid-frame: assert rst_n = 0 during data bit 4 of 0x55.
  - tx = 1 immediately, no further transitions.
  - After release, a new byte 0x81 is sent correctly.
- With UART_TX_PARITY_EN and STOP_BITS = 2, send 0x07: expect parity bit = 1 (even parity), then 20 cycles high; frame is 120 cycles.
